// File: rtl/dra_pkg.sv
// Shared constants for the packet-RAM port-b arbiter: default geometry and status bit indices.
package dra_pkg;

  localparam int NUM_PE   = 3;
  localparam int ADDR_W   = 16;
  localparam int DATA_W   = 512;
  localparam int RD_LAT   = 2;
  localparam int LOCK_MAX = 8;

  // Bit positions inside the internal status vector that drives o_busy.
  localparam int STATUS_RD_INFLIGHT = 0;
  localparam int STATUS_LOCKED      = 1;
  localparam int STATUS_W           = 2;

endpackage

// File: rtl/dra_rr_pick.sv
// Rotate-priority one-hot picker: first set bit of req_i searching from ptr_i upward, wrapping.
module dra_rr_pick #(
  parameter int N  = 3,
  parameter int PW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o
);

  logic found;

  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < N; i++) begin
        if (!found && req_i[i] && (i == (int'(ptr_i) + k) % N)) begin
          gnt_o[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dra_pktram_rr_arbiter.sv
// Round-robin arbiter/sequencer for the shared packet-RAM core port with burst locking and tagged
// read return. Optional per-PE statistics ports are built when DRA_ARB_STATS_EN is defined.
module dra_pktram_rr_arbiter #(
  parameter int NUM_PE   = dra_pkg::NUM_PE,
  parameter int ADDR_W   = dra_pkg::ADDR_W,
  parameter int DATA_W   = dra_pkg::DATA_W,
  parameter int RD_LAT   = dra_pkg::RD_LAT,
  parameter int LOCK_MAX = dra_pkg::LOCK_MAX
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic [NUM_PE-1:0]        i_req,
  input  logic [NUM_PE-1:0]        i_req_wr,
  input  logic [NUM_PE-1:0]        i_req_lock,
  input  logic [ADDR_W*NUM_PE-1:0] i_req_addr,
  input  logic [DATA_W*NUM_PE-1:0] i_req_wdata,
  output logic [NUM_PE-1:0]        o_gnt,
  output logic                     o_wren_pktRAM,
  output logic [ADDR_W-1:0]        o_addr_pktRAM,
  output logic [DATA_W-1:0]        o_din_pktRAM,
  input  logic [DATA_W-1:0]        i_dout_pktRAM,
  output logic [DATA_W-1:0]        o_rdata,
  output logic [NUM_PE-1:0]        o_rvalid,
  output logic                     o_busy
`ifdef DRA_ARB_STATS_EN
  ,
  output logic [32*NUM_PE-1:0]     o_gnt_cnt,
  output logic [16*NUM_PE-1:0]     o_max_wait
`endif
);

  import dra_pkg::*;

  localparam int PW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int CW = $clog2(LOCK_MAX + 1);

  logic              en_q;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              lock_vld_q, lock_vld_d;
  logic [PW-1:0]     lock_own_q, lock_own_d;
  logic [CW-1:0]     lock_cnt_q, lock_cnt_d;
  logic [NUM_PE-1:0] rr_gnt, gnt;
  logic              lock_hit, accept, sel_wr, rd_inflight;
  logic [PW-1:0]     gnt_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic [STATUS_W-1:0] status;

  logic              wren_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] din_q, rdata_q;
  logic [NUM_PE-1:0] rvalid_q;
  logic [NUM_PE-1:0] rd_pipe_q [RD_LAT+1];

  dra_rr_pick #(.N(NUM_PE), .PW(PW)) u_pick (
    .req_i (i_req),
    .ptr_i (rr_ptr_q),
    .gnt_o (rr_gnt)
  );

  assign lock_hit = lock_vld_q && i_req[lock_own_q] && (lock_cnt_q < CW'(LOCK_MAX));

  // en_q keeps the grant quiet until the first clock after reset release.
  always_comb begin
    gnt = '0;
    if (en_q) gnt = lock_hit ? (NUM_PE'(1) << lock_own_q) : rr_gnt;
  end

  assign accept = |gnt;

  always_comb begin
    gnt_idx   = '0;
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      if (gnt[i]) begin
        gnt_idx   = PW'(i);
        sel_wr    = i_req_wr[i];
        sel_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = i_req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // A beat that brings the count to LOCK_MAX is the last one; the lock is dropped with it.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_vld_d = lock_vld_q;
    lock_own_d = lock_own_q;
    lock_cnt_d = lock_cnt_q;
    if (accept) begin
      rr_ptr_d   = (gnt_idx == PW'(NUM_PE - 1)) ? '0 : gnt_idx + 1'b1;
      lock_cnt_d = (lock_vld_q && (gnt_idx == lock_own_q)) ? lock_cnt_q + 1'b1 : CW'(1);
      lock_own_d = gnt_idx;
      lock_vld_d = i_req_lock[gnt_idx] && (lock_cnt_d < CW'(LOCK_MAX));
    end else if (lock_vld_q && !i_req[lock_own_q]) begin
      lock_vld_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      en_q       <= 1'b0;
      rr_ptr_q   <= '0;
      lock_vld_q <= 1'b0;
      lock_own_q <= '0;
      lock_cnt_q <= '0;
      wren_q     <= 1'b0;
      addr_q     <= '0;
      din_q      <= '0;
      rdata_q    <= '0;
      rvalid_q   <= '0;
      for (int k = 0; k <= RD_LAT; k++) rd_pipe_q[k] <= '0;
    end else begin
      en_q       <= 1'b1;
      rr_ptr_q   <= rr_ptr_d;
      lock_vld_q <= lock_vld_d;
      lock_own_q <= lock_own_d;
      lock_cnt_q <= lock_cnt_d;
      wren_q     <= accept && sel_wr;
      if (accept)           addr_q <= sel_addr;
      if (accept && sel_wr) din_q  <= sel_wdata;
      rd_pipe_q[0] <= (accept && !sel_wr) ? gnt : '0;
      for (int k = 1; k <= RD_LAT; k++) rd_pipe_q[k] <= rd_pipe_q[k-1];
      rvalid_q <= rd_pipe_q[RD_LAT];
      if (|rd_pipe_q[RD_LAT]) rdata_q <= i_dout_pktRAM;
    end
  end

  always_comb begin
    rd_inflight = 1'b0;
    for (int k = 0; k <= RD_LAT; k++) rd_inflight = rd_inflight | (|rd_pipe_q[k]);
  end

  assign status[STATUS_RD_INFLIGHT] = rd_inflight;
  assign status[STATUS_LOCKED]      = lock_vld_q;

  assign o_gnt         = gnt;
  assign o_wren_pktRAM = wren_q;
  assign o_addr_pktRAM = addr_q;
  assign o_din_pktRAM  = din_q;
  assign o_rdata       = rdata_q;
  assign o_rvalid      = rvalid_q;
  assign o_busy        = |status;

`ifdef DRA_ARB_STATS_EN
  genvar gi;
  generate
    for (gi = 0; gi < NUM_PE; gi++) begin : g_stats
      logic [31:0] cnt_q;
      logic [15:0] run_q, max_q, run_inc;

      assign run_inc = (run_q == 16'hFFFF) ? run_q : run_q + 16'd1;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          cnt_q <= '0;
          run_q <= '0;
          max_q <= '0;
        end else begin
          if (gnt[gi]) cnt_q <= cnt_q + 32'd1;
          if (en_q && i_req[gi] && !gnt[gi]) begin
            run_q <= run_inc;
            if (run_inc > max_q) max_q <= run_inc;
          end else begin
            run_q <= '0;
          end
        end
      end

      assign o_gnt_cnt[gi*32 +: 32]  = cnt_q;
      assign o_max_wait[gi*16 +: 16] = max_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_dra_pktram_rr_arbiter.sv
// Self-checking bench for dra_pktram_rr_arbiter: grant table plus a read-return scoreboard.
// Statistics checks are compiled in when DRA_ARB_STATS_EN is defined.
module tb_dra_pktram_rr_arbiter;

  localparam int NPE = 3;
  localparam int AW  = 16;
  localparam int DW  = 512;
  localparam int RDL = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NPE-1:0]    req, wr, lock, gnt, rvalid;
  logic [AW*NPE-1:0] addr;
  logic [DW*NPE-1:0] wdata;
  logic              wren, busy;
  logic [AW-1:0]     ram_addr;
  logic [DW-1:0]     din, rdata;
  logic [DW-1:0]     dout = '0;
  logic [AW-1:0]     ram_a1 = '0;
`ifdef DRA_ARB_STATS_EN
  logic [32*NPE-1:0] gnt_cnt;
  logic [16*NPE-1:0] max_wait;
`endif

  dra_pktram_rr_arbiter dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_req         (req),
    .i_req_wr      (wr),
    .i_req_lock    (lock),
    .i_req_addr    (addr),
    .i_req_wdata   (wdata),
    .o_gnt         (gnt),
    .o_wren_pktRAM (wren),
    .o_addr_pktRAM (ram_addr),
    .o_din_pktRAM  (din),
    .i_dout_pktRAM (dout),
    .o_rdata       (rdata),
    .o_rvalid      (rvalid),
    .o_busy        (busy)
`ifdef DRA_ARB_STATS_EN
    ,
    .o_gnt_cnt     (gnt_cnt),
    .o_max_wait    (max_wait)
`endif
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RAM model: address sampled one edge after it appears, data one edge later (latency 2).
  function automatic logic [DW-1:0] ram_data(input logic [AW-1:0] a);
    return {16{~a, a}};
  endfunction

  always @(posedge clk) begin
    ram_a1 <= ram_addr;
    dout   <= ram_data(ram_a1);
    cyc    <= cyc + 1;
  end

  typedef struct {
    logic [NPE-1:0] pe;
    logic [DW-1:0]  data;
    int             cyc;
  } exp_t;
  exp_t sb[$];
  exp_t e;

  logic          pend_wr = 1'b0;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_din;

  // Scoreboard: accepted reads are pushed with their due cycle; writes are expected the next cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      pend_wr = 1'b0;
    end else begin
      chk("wren", DW'(wren), DW'(pend_wr));
      if (pend_wr) begin
        chk("wr_addr", DW'(ram_addr), DW'(pend_addr));
        chk("wr_din", din, pend_din);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        chk("rvalid", DW'(rvalid), DW'(e.pe));
        chk("rdata", rdata, e.data);
        $display("rd return pe=%b data[31:0]=%h cyc=%0d", rvalid, rdata[31:0], cyc);
      end else begin
        chk("rvalid_idle", DW'(rvalid), '0);
      end
      chk("gnt_legal", DW'((gnt & ~req) != 0 || $countones(gnt) > 1), '0);
      pend_wr = 1'b0;
      for (int i = 0; i < NPE; i++) begin
        if (req[i] && gnt[i]) begin
          if (wr[i]) begin
            pend_wr   = 1'b1;
            pend_addr = addr[i*AW +: AW];
            pend_din  = wdata[i*DW +: DW];
          end else begin
            sb.push_back('{pe: NPE'(1 << i), data: ram_data(addr[i*AW +: AW]), cyc: cyc + RDL + 2});
          end
        end
      end
    end
  end

  typedef struct packed {
    logic [NPE-1:0] req;
    logic [NPE-1:0] wr;
    logic [NPE-1:0] lock;
    logic [NPE-1:0] gnt;
  } vec_t;
  vec_t vecs[64];
  int   nv = 0;

  task automatic add_vec(input logic [2:0] rq, input logic [2:0] w, input logic [2:0] lk, input logic [2:0] g);
    vecs[nv] = '{req: rq, wr: w, lock: lk, gnt: g};
    nv++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fairness, 8-beat lock limit, lock drop by i_req / i_req_lock, writes mixed in.
    for (int k = 0; k < 6; k++) add_vec(3'b111, 3'b000, 3'b000, 3'(1 << (k % 3)));
    add_vec(3'b111, 3'b000, 3'b010, 3'b001);
    for (int k = 0; k < 8; k++) add_vec(3'b111, 3'b000, 3'b010, 3'b010);
    add_vec(3'b111, 3'b000, 3'b010, 3'b100);
    add_vec(3'b111, 3'b000, 3'b000, 3'b001);
    add_vec(3'b111, 3'b000, 3'b010, 3'b010);
    add_vec(3'b111, 3'b000, 3'b010, 3'b010);
    add_vec(3'b101, 3'b000, 3'b000, 3'b100);
    add_vec(3'b011, 3'b000, 3'b000, 3'b001);
    add_vec(3'b111, 3'b000, 3'b010, 3'b010);
    add_vec(3'b111, 3'b000, 3'b000, 3'b010);
    add_vec(3'b111, 3'b000, 3'b000, 3'b100);
    add_vec(3'b000, 3'b000, 3'b000, 3'b000);
    add_vec(3'b111, 3'b111, 3'b000, 3'b001);
    add_vec(3'b110, 3'b010, 3'b000, 3'b010);
    add_vec(3'b011, 3'b001, 3'b000, 3'b001);
    add_vec(3'b010, 3'b000, 3'b000, 3'b010);

    rst_n = 1'b1;
    req   = 3'b111;
    wr    = '0;
    lock  = '0;
    addr  = '0;
    wdata = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", DW'(gnt), '0);
    chk("rst_wren", DW'(wren), '0);
    chk("rst_addr", DW'(ram_addr), '0);
    chk("rst_din", din, '0);
    chk("rst_rdata", rdata, '0);
    chk("rst_rvalid", DW'(rvalid), '0);
    chk("rst_busy", DW'(busy), '0);
    step();
    rst_n = 1'b1;
    step();

    for (int r = 0; r < nv; r++) begin
      req  = vecs[r].req;
      wr   = vecs[r].wr;
      lock = vecs[r].lock;
      for (int i = 0; i < NPE; i++) begin
        addr[i*AW +: AW]  = AW'(16'h0100 + r * 4 + i);
        wdata[i*DW +: DW] = {16{32'(r * 8 + i) ^ 32'hC3C3_0000}};
      end
      @(negedge clk);
      $display("vec %0d req=%b wr=%b lock=%b gnt=%b", r, req, wr, lock, gnt);
      chk($sformatf("gnt_vec%0d", r), DW'(gnt), DW'(vecs[r].gnt));
      step();
    end

    req = '0; wr = '0; lock = '0;
    repeat (8) step();
    chk("sb_drain", DW'(sb.size()), '0);
    chk("idle_busy", DW'(busy), '0);

    // PE2 write: one-cycle-later RAM write strobe, no read return.
    req = 3'b100;
    wr  = 3'b100;
    addr[2*AW +: AW]  = 16'h0040;
    wdata[2*DW +: DW] = {64{8'hA5}};
    @(negedge clk);
    chk("wr_gnt", DW'(gnt), DW'(3'b100));
    step();
    req = '0; wr = '0;
    @(negedge clk);
    $display("write addr=%h wren=%b", ram_addr, wren);
    chk("wr_wren_on", DW'(wren), DW'(1'b1));
    chk("wr_addr_40", DW'(ram_addr), DW'(16'h0040));
    chk("wr_din_a5", din, {64{8'hA5}});
    chk("wr_busy", DW'(busy), '0);
    step();
    @(negedge clk);
    chk("wr_wren_off", DW'(wren), '0);
    chk("wr_addr_hold", DW'(ram_addr), DW'(16'h0040));
    repeat (5) step();

    // Reset one cycle after a read accept: the read must never return.
    req = 3'b001;
    addr[0 +: AW] = 16'h0077;
    @(negedge clk);
    chk("rstrd_gnt", DW'(gnt), DW'(3'b001));
    step();
    req   = '0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rstrd_rvalid", DW'(rvalid), '0);
    chk("rstrd_busy", DW'(busy), '0);
    repeat (2) step();
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rstrd_no_rvalid", DW'(rvalid), '0);
      step();
    end

`ifdef DRA_ARB_STATS_EN
    req = 3'b001;
    repeat (5) step();
    req = '0;
    @(negedge clk);
    chk("stat_cnt0_5", DW'(gnt_cnt[0 +: 32]), DW'(32'd5));
    step();
    req = 3'b100;
    step();
    req = 3'b111;
    repeat (3) step();
    req = '0;
    @(negedge clk);
    chk("stat_cnt0_6", DW'(gnt_cnt[0 +: 32]), DW'(32'd6));
    chk("stat_cnt2_2", DW'(gnt_cnt[64 +: 32]), DW'(32'd2));
    chk("stat_wait2", DW'(max_wait[32 +: 16]), DW'(16'd2));
    chk("stat_wait1", DW'(max_wait[16 +: 16]), DW'(16'd1));
    step();
`endif

    repeat (8) step();
    chk("sb_final", DW'(sb.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
